// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
// Receiver state encoding, parity selectors and baud divider math.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

  function automatic int baud_cycles(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: line synchronizer, bit timer and 3-sample vote.
// The timer is held at zero while run is low so a start edge aligns it.
module uart_bit_sampler #(
  parameter int CYCLES = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  input  logic run,
  output logic rxs,
  output logic sample_strobe,
  output logic sample_bit
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int H  = CYCLES / 2;

  localparam logic [CW-1:0] C_LAST = CW'(CYCLES - 1);
  localparam logic [CW-1:0] C_S0   = CW'(H - 1);
  localparam logic [CW-1:0] C_S1   = CW'(H);
  localparam logic [CW-1:0] C_S2   = CW'(H + 1);

  logic          sync1;
  logic          sync2;
  logic          s0;
  logic          s1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      s0    <= 1'b1;
      s1    <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
      if (!run)
        cnt <= '0;
      else if (cnt == C_LAST)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
      if (cnt == C_S0)
        s0 <= sync2;
      if (cnt == C_S1)
        s1 <= sync2;
    end
  end

  assign rxs           = sync2;
  assign sample_strobe = run && (cnt == C_S2);
  // third vote is the live synchronized line at the decision cycle
  assign sample_bit    = (s0 & s1) | (s0 & sync2) | (s1 & sync2);

endmodule

// File: rtl/rx_param.sv
// rx_param: parametrised UART receiver with valid/ready output.
// Frame FSM, LSB-first shifter, parity/stop checks, overrun and break.
module rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_EN     = 1,
  parameter int PARITY        = PARITY_ODD,
  parameter int STOP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int BAUD_CLOCK_CYCLES =
    baud_cycles(CLK_FREQUENCY, BAUD_RATE);
  localparam bit HAS_PAR = (PARITY_EN != 0);
  localparam bit ODD     = (PARITY == PARITY_ODD);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (BAUD_CLOCK_CYCLES < 8) begin : g_baud_chk
    $error("rx_param: BAUD_CLOCK_CYCLES below 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_chk
    $error("rx_param: DATA_BITS outside 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("rx_param: STOP_BITS must be 1 or 2");
  end

  rx_state_e            state;
  logic [DATA_BITS-1:0] sh;
  logic [3:0]           bcnt;
  logic                 perr;
  logic                 ferr;
  logic                 par_bit;
  logic                 run;
  logic                 rxs;
  logic                 strobe;
  logic                 bit_v;
  logic                 ferr_n;
  logic                 brk;

  assign run = (state == RX_START) || (state == RX_DATA) ||
               (state == RX_PARITY) || (state == RX_STOP);
  assign busy   = (state != RX_IDLE);
  assign ferr_n = ferr | ~bit_v;
  assign brk    = (sh == '0) && (!HAS_PAR || !par_bit) && ferr_n;

  uart_bit_sampler #(
    .CYCLES (BAUD_CLOCK_CYCLES)
  ) u_sampler (
    .clk           (clk),
    .rst           (rst),
    .rx_in         (rx_in),
    .run           (run),
    .rxs           (rxs),
    .sample_strobe (strobe),
    .sample_bit    (bit_v)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RX_IDLE;
      sh         <= '0;
      bcnt       <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      par_bit    <= 1'b0;
      dout       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      break_det <= 1'b0;
      if (valid && ready)
        valid <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          if (!rxs) begin
            state <= RX_START;
            bcnt  <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
          end
        end
        RX_START: begin
          if (strobe)
            state <= bit_v ? RX_IDLE : RX_DATA;
        end
        RX_DATA: begin
          if (strobe) begin
            sh <= {bit_v, sh[DATA_BITS-1:1]};
            if (bcnt == LAST_DATA) begin
              bcnt  <= '0;
              state <= HAS_PAR ? RX_PARITY : RX_STOP;
            end else begin
              bcnt <= bcnt + 4'd1;
            end
          end
        end
        RX_PARITY: begin
          if (strobe) begin
            par_bit <= bit_v;
            perr    <= bit_v != ((^sh) ^ ODD);
            state   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (strobe) begin
            ferr <= ferr_n;
            if (bcnt == LAST_STOP) begin
              // a pending unread frame wins; the new one is dropped
              if (brk) begin
                break_det <= 1'b1;
              end else if (!valid || ready) begin
                dout       <= sh;
                parity_err <= perr;
                frame_err  <= ferr_n;
                valid      <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state <= ferr_n ? RX_WAIT_HIGH : RX_IDLE;
            end else begin
              bcnt <= bcnt + 4'd1;
            end
          end
        end
        RX_WAIT_HIGH: begin
          if (rxs)
            state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_param.sv
// tb_rx_param: directed frames into three receiver configurations.
// A frame-level event model predicts every output cycle by cycle.
module tb_rx_param;

  localparam int B   = 16;
  localparam int H   = 8;
  localparam int NB  [3] = '{8, 5, 9};
  localparam int PEN [3] = '{1, 0, 1};
  localparam int PAR [3] = '{1, 1, 0};
  localparam int NS  [3] = '{1, 2, 1};

  typedef struct {
    int         id;
    int         at;
    logic [8:0] d;
    bit         pe;
    bit         fe;
    bit         brk;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx;
  logic [2:0] rdy;
  wire  [7:0] d0;
  wire  [4:0] d1;
  wire  [8:0] d2;
  wire  [2:0] vq, pq, fq, oq, bq, yq;

  int nchk  = 0;
  int npass = 0;
  int cyc   = 0;

  ev_t        evq[$];
  bit         mv  [3];
  logic [8:0] md  [3];
  bit         mpe [3];
  bit         mfe [3];

  bit         cap_hit [3];
  logic [8:0] cap_d   [3];
  bit         cap_pe  [3];
  bit         cap_fe  [3];
  int         cap_cyc [3];
  int         ovr_cnt [3];
  int         brk_cnt [3];

  always #5 clk = ~clk;

  rx_param #(
    .CLK_FREQUENCY (1_600_000), .BAUD_RATE (100_000),
    .DATA_BITS (8), .PARITY_EN (1), .PARITY (1), .STOP_BITS (1)
  ) u_dut (
    .clk (clk), .rst (rst), .rx_in (rx[0]), .dout (d0),
    .valid (vq[0]), .ready (rdy[0]), .parity_err (pq[0]),
    .frame_err (fq[0]), .overrun (oq[0]), .break_det (bq[0]),
    .busy (yq[0])
  );

  rx_param #(
    .CLK_FREQUENCY (1_600_000), .BAUD_RATE (100_000),
    .DATA_BITS (5), .PARITY_EN (0), .PARITY (1), .STOP_BITS (2)
  ) u_d5 (
    .clk (clk), .rst (rst), .rx_in (rx[1]), .dout (d1),
    .valid (vq[1]), .ready (rdy[1]), .parity_err (pq[1]),
    .frame_err (fq[1]), .overrun (oq[1]), .break_det (bq[1]),
    .busy (yq[1])
  );

  rx_param #(
    .CLK_FREQUENCY (1_600_000), .BAUD_RATE (100_000),
    .DATA_BITS (9), .PARITY_EN (1), .PARITY (0), .STOP_BITS (1)
  ) u_d9 (
    .clk (clk), .rst (rst), .rx_in (rx[2]), .dout (d2),
    .valid (vq[2]), .ready (rdy[2]), .parity_err (pq[2]),
    .frame_err (fq[2]), .overrun (oq[2]), .break_det (bq[2]),
    .busy (yq[2])
  );

  function automatic logic [8:0] dsel(input int i);
    case (i)
      0:       return {1'b0, d0};
      1:       return {4'b0, d1};
      default: return d2;
    endcase
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp)
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, i, got, exp);
    else
      npass++;
  endtask

  always @(posedge clk) begin : cmp
    logic [2:0] rs;
    bit         eo [3];
    bit         eb [3];
    int         q;
    int         i;
    rs = rdy;
    #1;
    cyc++;
    if (!rst) begin
      evq.delete();
      for (int k = 0; k < 3; k++) begin
        mv[k] = 0; md[k] = '0; mpe[k] = 0; mfe[k] = 0;
        chk("rst_valid", k, vq[k], 0);
        chk("rst_dout", k, dsel(k), 0);
        chk("rst_busy", k, yq[k], 0);
        chk("rst_flags", k, {pq[k], fq[k], oq[k], bq[k]}, 0);
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        eo[k] = 0;
        eb[k] = 0;
        if (mv[k] && rs[k])
          mv[k] = 0;
      end
      q = 0;
      while (q < evq.size()) begin
        if (evq[q].at == cyc) begin
          i = evq[q].id;
          if (evq[q].brk) begin
            eb[i] = 1;
          end else if (!mv[i]) begin
            mv[i] = 1; md[i] = evq[q].d;
            mpe[i] = evq[q].pe; mfe[i] = evq[q].fe;
          end else begin
            eo[i] = 1;
          end
          evq.delete(q);
        end else begin
          q++;
        end
      end
      for (int k = 0; k < 3; k++) begin
        chk("valid", k, vq[k], mv[k]);
        chk("overrun", k, oq[k], eo[k]);
        chk("break_det", k, bq[k], eb[k]);
        chk("dout", k, dsel(k), md[k]);
        if (mv[k]) begin
          chk("parity_err", k, pq[k], mpe[k]);
          chk("frame_err", k, fq[k], mfe[k]);
        end
        if (vq[k]) begin
          if (!cap_hit[k])
            cap_cyc[k] = cyc;
          cap_hit[k] = 1;
          cap_d[k]   = dsel(k);
          cap_pe[k]  = pq[k];
          cap_fe[k]  = fq[k];
        end
        if (oq[k]) ovr_cnt[k]++;
        if (bq[k]) brk_cnt[k]++;
      end
    end
  end

  task automatic line(input int i, input bit v, input bit g);
    rx[i] = v;
    if (g) begin
      repeat (H) @(negedge clk);
      rx[i] = ~v;
      @(negedge clk);
      rx[i] = v;
      repeat (B - H - 1) @(negedge clk);
    end else begin
      repeat (B) @(negedge clk);
    end
  endtask

  // stp[s] is the value driven in stop bit s; gj is a frame bit index
  task automatic send(input int i, input logic [8:0] d, input bit flip,
                      input bit [1:0] stp, input int gj);
    logic [8:0] dm;
    bit         pb;
    bit         fe;
    int         nb;
    int         last;
    ev_t        e;
    nb   = NB[i];
    dm   = d & 9'((1 << nb) - 1);
    pb   = (^dm) ^ (PAR[i] != 0) ^ flip;
    fe   = 0;
    for (int s = 0; s < NS[i]; s++)
      if (!stp[s]) fe = 1;
    last  = nb + PEN[i] + NS[i];
    e.id  = i;
    e.at  = cyc + last * B + H + 5;
    e.d   = dm;
    e.pe  = flip && (PEN[i] != 0);
    e.fe  = fe;
    e.brk = (dm == 0) && (PEN[i] == 0 || !pb) && fe;
    evq.push_back(e);
    line(i, 1'b0, gj == 0);
    for (int j = 0; j < nb; j++)
      line(i, dm[j], gj == j + 1);
    if (PEN[i] != 0)
      line(i, pb, gj == nb + 1);
    for (int s = 0; s < NS[i]; s++)
      line(i, stp[s], 1'b0);
  endtask

  task automatic ack(input int i);
    rdy[i] = 1'b1;
    @(negedge clk);
    rdy[i] = 1'b0;
    chk("ack_drop", i, vq[i], 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         k0;
    int         o0;
    int         b0;
    logic [8:0] d;
    bit         f;
    rst = 1'b0;
    rx  = '1;
    rdy = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid", 0, vq[0], 0);
    chk("reset_busy", 0, yq[0], 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    cap_hit[0] = 0; k0 = cyc;
    send(0, 9'hA5, 0, 2'b11, -1);
    chk("a5_hit", 0, cap_hit[0], 1);
    chk("a5_dout", 0, cap_d[0], 9'hA5);
    chk("a5_perr", 0, cap_pe[0], 0);
    chk("a5_ferr", 0, cap_fe[0], 0);
    chk("a5_latency", 0, cap_cyc[0] - k0, 173);
    ack(0);

    cap_hit[0] = 0;
    send(0, 9'h3C, 1, 2'b11, -1);
    chk("3c_dout", 0, cap_d[0], 9'h3C);
    chk("3c_perr", 0, cap_pe[0], 1);
    ack(0);

    cap_hit[0] = 0; b0 = brk_cnt[0];
    send(0, 9'h00, 1, 2'b00, -1);
    chk("brk_pulse", 0, brk_cnt[0] - b0, 1);
    chk("brk_novalid", 0, cap_hit[0], 0);
    chk("brk_busy", 0, yq[0], 1);
    repeat (2 * B) @(negedge clk);
    chk("brk_busy_low", 0, yq[0], 1);
    rx[0] = 1'b1;
    repeat (6) @(negedge clk);
    chk("brk_busy_rel", 0, yq[0], 0);

    o0 = ovr_cnt[0];
    send(0, 9'h55, 0, 2'b11, -1);
    send(0, 9'hAA, 0, 2'b11, -1);
    chk("ovr_dout", 0, d0, 8'h55);
    chk("ovr_valid", 0, vq[0], 1);
    chk("ovr_pulse", 0, ovr_cnt[0] - o0, 1);
    ack(0);

    cap_hit[0] = 0; b0 = brk_cnt[0];
    rx[0] = 1'b0;
    repeat (5) @(negedge clk);
    rx[0] = 1'b1;
    repeat (3 * B) @(negedge clk);
    chk("glitch_novalid", 0, cap_hit[0], 0);
    chk("glitch_busy", 0, yq[0], 0);
    chk("glitch_nobrk", 0, brk_cnt[0] - b0, 0);

    cap_hit[0] = 0;
    send(0, 9'h81, 0, 2'b11, 2);
    chk("vote_dout", 0, cap_d[0], 9'h81);
    chk("vote_perr", 0, cap_pe[0], 0);
    ack(0);

    line(0, 1'b0, 1'b0);
    line(0, 1'b0, 1'b0);
    line(0, 1'b1, 1'b0);
    line(0, 1'b1, 1'b0);
    line(0, 1'b1, 1'b0);
    rx[0] = 1'b1;
    repeat (H) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_valid", 0, vq[0], 0);
    chk("arst_dout", 0, d0, 0);
    chk("arst_busy", 0, yq[0], 0);
    chk("arst_flags", 0, {pq[0], fq[0], oq[0], bq[0]}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    cap_hit[0] = 0;
    send(0, 9'h7E, 0, 2'b11, -1);
    chk("post_rst_dout", 0, cap_d[0], 9'h7E);
    chk("post_rst_perr", 0, cap_pe[0], 0);
    ack(0);

    rdy[1] = 1'b1;
    for (int n = 0; n < 6; n++) begin
      d = 9'($urandom_range(0, 31));
      cap_hit[1] = 0;
      send(1, d, 0, 2'b11, -1);
      chk("d5_hit", 1, cap_hit[1], 1);
      chk("d5_dout", 1, cap_d[1], d);
      chk("d5_ferr", 1, cap_fe[1], 0);
    end
    cap_hit[1] = 0;
    send(1, 9'h13, 0, 2'b01, -1);
    rx[1] = 1'b1;
    chk("d5_stop2_dout", 1, cap_d[1], 9'h13);
    chk("d5_stop2_ferr", 1, cap_fe[1], 1);
    repeat (4) @(negedge clk);

    rdy[2] = 1'b1;
    for (int n = 0; n < 6; n++) begin
      d = 9'($urandom_range(0, 511));
      f = (n == 2);
      cap_hit[2] = 0;
      send(2, d, f, 2'b01, -1);
      chk("d9_hit", 2, cap_hit[2], 1);
      chk("d9_dout", 2, cap_d[2], d);
      chk("d9_perr", 2, cap_pe[2], f);
    end
    cap_hit[2] = 0;
    send(2, 9'h101, 0, 2'b01, -1);
    chk("d9_even_dout", 2, cap_d[2], 9'h101);
    chk("d9_even_perr", 2, cap_pe[2], 0);

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
